mem_addr_sequencer: RTL and testbench
=====================================

Name: mem_addr_sequencer

Overview:
Parametrised successor to the address-bus select mux. It arbitrates between the instruction-fetch port (PC) and the data-access port (LDR/STR address from the register bank), and drives one registered address bus to RAM. It holds each access for a configurable number of wait states and returns a one-cycle acknowledge to the winning requester. It sits between the control unit / register bank and the RAM, replacing the combinational select.

Parameters:
ADDR_W, 16, width of the memory address bus and of the data-access address.
PC_W, 8, width of the program counter; must be <= ADDR_W; zero-extended to ADDR_W.
WAIT_STATES, 1, extra cycles each access is held on the bus; legal range 0..15.

Ports:
clk  input  1  system clock, rising edge.
reset_n  input  1  asynchronous, active-low reset.
fetch_req  input  1  instruction fetch request; level, held until fetch_ack.
fetch_pc  input  PC_W  fetch address (PC).
data_req  input  1  data access request (LDR or STR); level, held until data_ack.
data_addr  input  ADDR_W  data access address from the register bank.
data_we  input  1  1 = STR (write), 0 = LDR (read).
mem_addr  output  ADDR_W  registered address to RAM.
mem_en  output  1  access-valid strobe to RAM.
mem_we  output  1  write strobe to RAM; valid only while mem_en = 1.
fetch_ack  output  1  one-cycle pulse that completes a fetch.
data_ack  output  1  one-cycle pulse that completes a data access.
busy  output  1  high while in ACCESS.

Behaviour:
- Reset (reset_n = 0, asynchronous): state = IDLE, mem_addr = 0, mem_en = 0, mem_we = 0, both acks = 0, busy = 0, wait counter = 0, last_grant = FETCH. A reset during ACCESS aborts the access immediately. No ack is issued for the aborted access.
- FSM has two states, IDLE and ACCESS.
- IDLE, no request: mem_en = 0 and mem_we = 0. mem_addr holds its last value.
- IDLE, any request at a rising edge: arbitrate and register the winner. Registered values:
  - mem_addr = data_addr, or {zeros, fetch_pc} for a fetch.
  - mem_we = data_we for a data access, 0 for a fetch.
  - grant_sel = winner.
  - counter = WAIT_STATES.
  - Go to ACCESS.
- ACCESS: mem_en = 1 and busy = 1.
  - counter > 0: decrement by 1 each cycle.
  - counter == 0: this is the final access cycle. Assert the ack of grant_sel for this cycle only. At the next edge, return to IDLE and clear mem_we.
- Timing: a request sampled at edge T0 gives mem_en high for cycles T1..T1+WAIT_STATES. The ack is high in cycle T1+WAIT_STATES. The FSM is in IDLE from T2+WAIT_STATES.
- A requester must drop its req at the edge where its ack is high. A req still high at the next IDLE edge counts as a new request.
- Address and data_we inputs are sampled only at grant. Later changes have no effect on the access in flight.
- Request withdrawn during ACCESS: the access completes and the ack still pulses.
- Simultaneous requests in IDLE: default fixed priority, data wins. The fetch stays pending and is granted at the next IDLE edge.
- last_grant updates at every grant.
- The two acks are never high together.

Optional Feature:
MEM_SEQ_ROUND_ROBIN_EN.
- Defined: simultaneous requests go to the port not named by last_grant, so neither port can be starved.
- Undefined: fixed data priority as above. last_grant is still maintained but unused.

Test Plan:
- Reset with WAIT_STATES = 1, then fetch_req = 1 and fetch_pc = 0x05 -> mem_addr = 0x0005, mem_en = 1 for 2 cycles, mem_we = 0, fetch_ack pulses in the 2nd cycle, busy falls the next cycle.
- data_req = 1, data_addr = 0xBEEF, data_we = 1 -> mem_addr = 0xBEEF, mem_we = 1 with mem_en, data_ack pulses once, fetch_ack stays 0.
- fetch_req and data_req rise on the same edge (macro undefined) -> data served first (data_ack), then fetch (fetch_ack) with no idle request cycle lost. With macro defined and last_grant = DATA, the fetch is served first.
- WAIT_STATES = 0; data_addr changes mid-access and data_req drops early -> single-cycle access, mem_addr keeps the grant-time value, data_ack still pulses.
- reset_n pulsed low in the middle of a WAIT_STATES = 3 access -> all outputs go to 0 asynchronously, no ack, state = IDLE; the next request is served normally.
- fetch_req held high continuously -> back-to-back fetches: one fetch_ack every WAIT_STATES + 2 cycles and never two in consecutive cycles.

Source files
------------

// File: rtl/mem_addr_sequencer.sv
// Registered RAM address sequencer: arbitrates fetch vs data access, holds each access for WAIT_STATES.
// Optional MEM_SEQ_ROUND_ROBIN_EN: simultaneous requests alternate instead of fixed data priority.
module mem_addr_sequencer #(
   parameter int ADDR_W      = 16,
   parameter int PC_W        = 8,
   parameter int WAIT_STATES = 1
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              fetch_req,
   input  logic [PC_W-1:0]   fetch_pc,
   input  logic              data_req,
   input  logic [ADDR_W-1:0] data_addr,
   input  logic              data_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_en,
   output logic              mem_we,
   output logic              fetch_ack,
   output logic              data_ack,
   output logic              busy
);

   typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_e;

   localparam logic       GNT_FETCH = 1'b0;
   localparam logic       GNT_DATA  = 1'b1;
   localparam logic [3:0] WS_L      = 4'(WAIT_STATES);

   state_e              state_q, state_d;
   logic [3:0]          cnt_q, cnt_d;
   logic                grant_q, grant_d;
   logic                last_q, last_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic                we_q, we_d;
   logic                any_req, pick_data, last_cycle;

   assign any_req    = fetch_req | data_req;
   assign last_cycle = (state_q == ACCESS) && (cnt_q == 4'd0);

`ifdef MEM_SEQ_ROUND_ROBIN_EN
   // On contention serve whichever port did not win last time.
   assign pick_data = data_req && (!fetch_req || (last_q == GNT_FETCH));
`else
   assign pick_data = data_req;
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_q <= IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (any_req) state_d = ACCESS;
         ACCESS:  if (cnt_q == 4'd0) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      mem_en    = (state_q == ACCESS);
      busy      = (state_q == ACCESS);
      fetch_ack = last_cycle && (grant_q == GNT_FETCH);
      data_ack  = last_cycle && (grant_q == GNT_DATA);
      mem_addr  = addr_q;
      mem_we    = we_q;
   end

   // Address and direction are captured only at grant; inputs are ignored afterwards.
   always_comb begin
      cnt_d   = cnt_q;
      grant_d = grant_q;
      last_d  = last_q;
      addr_d  = addr_q;
      we_d    = we_q;
      if (state_q == IDLE) begin
         if (any_req) begin
            addr_d  = pick_data ? data_addr : ADDR_W'(fetch_pc);
            we_d    = pick_data & data_we;
            grant_d = pick_data ? GNT_DATA : GNT_FETCH;
            last_d  = pick_data ? GNT_DATA : GNT_FETCH;
            cnt_d   = WS_L;
         end
      end else if (cnt_q != 4'd0) begin
         cnt_d = cnt_q - 4'd1;
      end else begin
         we_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q   <= 4'd0;
         grant_q <= GNT_FETCH;
         last_q  <= GNT_FETCH;
         addr_q  <= '0;
         we_q    <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         grant_q <= grant_d;
         last_q  <= last_d;
         addr_q  <= addr_d;
         we_q    <= we_d;
      end
   end

endmodule

// File: tb/tb_mem_addr_sequencer.sv
// Scoreboard bench for mem_addr_sequencer; three instances cover WAIT_STATES = 1, 0 and 3.
module tb_mem_addr_sequencer;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        fetch_req = 1'b0, data_req = 1'b0, data_we = 1'b0;
   logic [7:0]  fetch_pc = '0;
   logic [15:0] data_addr = '0;

   logic [15:0] ma [3];
   logic        en [3], mw [3], fa [3], da [3], bz [3];

   typedef struct {bit is_data; logic [15:0] addr; bit we;} exp_t;
   exp_t sbq[$];
   int   total = 0, bad = 0, sel = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      mem_addr_sequencer #(
         .ADDR_W(16), .PC_W(8), .WAIT_STATES((g == 0) ? 1 : (g == 1) ? 0 : 3)
      ) u_dut (
         .clk(clk), .reset_n(reset_n),
         .fetch_req(fetch_req), .fetch_pc(fetch_pc),
         .data_req(data_req), .data_addr(data_addr), .data_we(data_we),
         .mem_addr(ma[g]), .mem_en(en[g]), .mem_we(mw[g]),
         .fetch_ack(fa[g]), .data_ack(da[g]), .busy(bz[g])
      );
   end

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", tag, act, exp);
      end
   endtask

   // Every ack pops the oldest expected access and checks port, address and direction.
   always @(negedge clk) begin
      exp_t e;
      if (reset_n === 1'b1 && (fa[sel] || da[sel])) begin
         chk("ack_excl", 32'(fa[sel] & da[sel]), 0);
         chk("sb_pending", 32'(sbq.size() != 0), 1);
         if (sbq.size() != 0) begin
            e = sbq.pop_front();
            chk("sb_port", 32'(da[sel]), 32'(e.is_data));
            chk("sb_addr", 32'(ma[sel]), 32'(e.addr));
            chk("sb_we",   32'(mw[sel]), 32'(e.we));
            chk("sb_en",   32'(en[sel]), 1);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic push(input bit is_data, input logic [15:0] a, input bit we);
      exp_t e;
      e.is_data = is_data; e.addr = a; e.we = we;
      sbq.push_back(e);
   endtask

   task automatic wait_ack(input bit is_data, input bit drop, output int cyc);
      bit got = 0;
      cyc = 0;
      while (!got && cyc < 40) begin
         tick();
         cyc++;
         got = is_data ? da[sel] : fa[sel];
      end
      chk(is_data ? "data_ack_seen" : "fetch_ack_seen", 32'(got), 1);
      if (got && drop) begin
         if (is_data) data_req = 1'b0;
         else         fetch_req = 1'b0;
      end
   endtask

   task automatic do_reset();
      reset_n = 1'b0; fetch_req = 1'b0; data_req = 1'b0;
      tick(); tick();
      sbq.delete();
      reset_n = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: got no finish want finish");
      $fatal(1);
   end

   initial begin
      int c;
      // ---- WAIT_STATES = 1 ----
      sel = 0;
      reset_n = 1'b0;
      tick();
      chk("rst_addr", 32'(ma[0]), 0);
      chk("rst_en",   32'(en[0]), 0);
      chk("rst_we",   32'(mw[0]), 0);
      chk("rst_acks", 32'({fa[0], da[0]}), 0);
      chk("rst_busy", 32'(bz[0]), 0);
      do_reset();

      fetch_pc = 8'h05; fetch_req = 1'b1; push(0, 16'h0005, 0);
      tick();
      chk("f_en1",   32'(en[0]), 1);
      chk("f_addr",  32'(ma[0]), 16'h0005);
      chk("f_we",    32'(mw[0]), 0);
      chk("f_ack1",  32'(fa[0]), 0);
      tick();
      chk("f_en2",   32'(en[0]), 1);
      chk("f_ack2",  32'(fa[0]), 1);
      fetch_req = 1'b0;
      tick();
      chk("f_busy_off", 32'(bz[0]), 0);
      chk("f_en_off",   32'(en[0]), 0);

      // request withdrawn in the first access cycle still completes
      data_addr = 16'h0042; data_we = 1'b0; data_req = 1'b1; push(1, 16'h0042, 0);
      tick();
      data_req = 1'b0;
      tick();
      chk("wd_ack", 32'(da[0]), 1);
      tick();
      chk("wd_idle", 32'(en[0]), 0);

      data_addr = 16'hBEEF; data_we = 1'b1; data_req = 1'b1; push(1, 16'hBEEF, 1);
      tick();
      chk("d_we",   32'(mw[0]), 1);
      chk("d_addr", 32'(ma[0]), 16'hBEEF);
      wait_ack(1, 1, c);
      chk("d_lat",  32'(c), 1);
      chk("d_fack", 32'(fa[0]), 0);
      tick();
      chk("d_we_idle", 32'(mw[0]), 0);
      chk("d_en_idle", 32'(en[0]), 0);

      // simultaneous requests; last grant was DATA
      fetch_pc = 8'h77; data_addr = 16'h1000; data_we = 1'b0;
      fetch_req = 1'b1; data_req = 1'b1;
`ifdef MEM_SEQ_ROUND_ROBIN_EN
      push(0, 16'h0077, 0); push(1, 16'h1000, 0);
      wait_ack(0, 1, c);
      chk("both_first_lat", 32'(c), 2);
      wait_ack(1, 1, c);
      chk("both_second_lat", 32'(c), 3);
`else
      push(1, 16'h1000, 0); push(0, 16'h0077, 0);
      wait_ack(1, 1, c);
      chk("both_first_lat", 32'(c), 2);
      wait_ack(0, 1, c);
      chk("both_second_lat", 32'(c), 3);
`endif
      tick();
      chk("both_idle", 32'(bz[0]), 0);

      // ---- WAIT_STATES = 0 ----
      sel = 1;
      do_reset();
      data_addr = 16'h1234; data_we = 1'b0; data_req = 1'b1; push(1, 16'h1234, 0);
      tick();
      chk("w0_en",   32'(en[1]), 1);
      chk("w0_ack",  32'(da[1]), 1);
      chk("w0_addr", 32'(ma[1]), 16'h1234);
      data_addr = 16'hFFFF; data_req = 1'b0;
      tick();
      chk("w0_en_off", 32'(en[1]), 0);
      chk("w0_hold",   32'(ma[1]), 16'h1234);
      chk("w0_ack_off", 32'(da[1]), 0);

      // ---- WAIT_STATES = 3, reset mid-access ----
      sel = 2;
      do_reset();
      data_addr = 16'hA5A5; data_we = 1'b1; data_req = 1'b1;
      tick(); tick();
      chk("ab_en",  32'(en[2]), 1);
      chk("ab_we",  32'(mw[2]), 1);
      #2 reset_n = 1'b0; data_req = 1'b0;
      #1;
      chk("ab_addr", 32'(ma[2]), 0);
      chk("ab_en0",  32'(en[2]), 0);
      chk("ab_we0",  32'(mw[2]), 0);
      chk("ab_busy", 32'(bz[2]), 0);
      chk("ab_ack",  32'({fa[2], da[2]}), 0);
      tick();
      reset_n = 1'b1;
      for (int i = 0; i < 5; i++) tick();
      chk("ab_quiet", 32'(bz[2]), 0);
      fetch_pc = 8'h3C; fetch_req = 1'b1; push(0, 16'h003C, 0);
      wait_ack(0, 1, c);
      chk("ab_next_lat", 32'(c), 4);

      // ---- WAIT_STATES = 1, continuous fetch ----
      sel = 0;
      do_reset();
      fetch_pc = 8'h10; fetch_req = 1'b1;
      for (int i = 0; i < 4; i++) push(0, 16'h0010, 0);
      wait_ack(0, 0, c);
      chk("bb_first", 32'(c), 2);
      for (int i = 0; i < 3; i++) begin
         wait_ack(0, (i == 2), c);
         chk("bb_period", 32'(c), 3);
      end
      tick(); tick();
      chk("bb_idle", 32'(bz[0]), 0);
      chk("sb_empty", 32'(sbq.size()), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
